instruction_memory_pipelined: RTL and testbench

INSTRUCTION_MEMORY_PIPELINED -- requirements
Module: instruction_memory_pipelined

---
 rtl/instruction_memory_pipelined_pkg.sv | 21 ++
 rtl/instruction_memory_pipelined_imem_array.sv | 34 +++
 rtl/instruction_memory_pipelined.sv | 131 +++++++++++++
 tb/tb_instruction_memory_pipelined.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_pipelined_pkg.sv
// Purpose : shared constants for the instruction fetch path (NOP encoding, fault counter, latency bounds).
// Latency : n/a (package only).
// Backpressure: n/a.
package instruction_memory_pipelined_pkg;

    // All-zero word doubles as the NOP returned for faulting fetches.
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // Width of the saturating fault counter exported by the fetch block.
    localparam int FAULT_CNT_W = 16;

    // Supported range for the read pipeline depth.
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/instruction_memory_pipelined_imem_array.sv
// Purpose : word-addressed instruction storage, one write port and one registered read port, no reset.
// Latency : read data valid one cycle after rd_en; writes land on the same rising edge.
// Backpressure: none; rd_en low holds rd_data, which the pipeline relies on during stalls.
// Ports   : clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered output.
module imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Power-up contents are all NOPs; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Purpose : pipelined instruction fetch memory with program-load port and fault detection.
// Latency : READ_LATENCY cycles from accepted request to response when not stalled.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and drops req_ready; load_en also drops req_ready.
// Ports   : clk, rst_n; req_valid/req_ready/req_addr fetch request; rsp_valid/rsp_ready/rsp_data/rsp_fault
//           response; load_en/load_addr/load_data program load; fault_count saturating fault tally.
module instruction_memory_pipelined
    import instruction_memory_pipelined_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_fault,
    input  logic                   load_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [DATA_WIDTH-1:0]  load_data,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_W   = DATA_WIDTH'(NOP_INSN);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("READ_LATENCY out of supported range");
    end

    logic                  stall;
    logic                  advance;
    logic                  accept;
    logic                  req_fault;
    logic                  load_ok;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [ADDR_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] rd_data;

    // Word indices are zero-extended so the range check cannot wrap.
    assign req_word  = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    assign load_word = {2'b00, load_addr[ADDR_WIDTH-1:2]};
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_word >= DEPTH_A);
    assign load_ok   = (load_addr[1:0] == 2'b00) && (load_word < DEPTH_A);

    assign stall     = rsp_valid && !rsp_ready;
    assign advance   = !stall;
    assign req_ready = !load_en && !stall;
    assign accept    = req_valid && req_ready;

    // Faulting fetches never read the array; rd_data simply holds its last value.
    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_en && load_ok),
        .wr_addr (load_word[IDX_W-1:0]),
        .wr_data (load_data),
        .rd_en   (accept && !req_fault),
        .rd_addr (req_word[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    // Stage 1 shares its edge with the array read register, so only the control bits live here.
    logic                  s1_vld;
    logic                  s1_fault;
    logic [DATA_WIDTH-1:0] s1_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_fault <= 1'b0;
        end else if (advance) begin
            s1_vld   <= accept;
            s1_fault <= accept && req_fault;
        end
    end

    assign s1_dat = (s1_vld && !s1_fault) ? rd_data : NOP_W;

    if (READ_LATENCY == 1) begin : g_lat1
        assign rsp_valid = s1_vld;
        assign rsp_fault = s1_fault;
        assign rsp_data  = s1_dat;
    end else begin : g_latn
        logic                  st_vld   [2:READ_LATENCY];
        logic                  st_fault [2:READ_LATENCY];
        logic [DATA_WIDTH-1:0] st_dat   [2:READ_LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 2; i <= READ_LATENCY; i++) begin
                    st_vld[i]   <= 1'b0;
                    st_fault[i] <= 1'b0;
                    st_dat[i]   <= NOP_W;
                end
            end else if (advance) begin
                st_vld[2]   <= s1_vld;
                st_fault[2] <= s1_fault;
                st_dat[2]   <= s1_dat;
                for (int i = 3; i <= READ_LATENCY; i++) begin
                    st_vld[i]   <= st_vld[i-1];
                    st_fault[i] <= st_fault[i-1];
                    st_dat[i]   <= st_dat[i-1];
                end
            end
        end

        assign rsp_valid = st_vld[READ_LATENCY];
        assign rsp_fault = st_fault[READ_LATENCY];
        assign rsp_data  = st_dat[READ_LATENCY];
    end

    // Faults are tallied when the consumer takes the response, not when the request enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_count <= '0;
        end else if (rsp_valid && rsp_ready && rsp_fault) begin
            fault_count <= sat_inc(fault_count);
        end
    end

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
module tb_instruction_memory_pipelined;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [15:0] fault_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    rsp_t        exp_q [$];
    rsp_t        got_q [$];
    logic [15:0] fc_m;

    instruction_memory_pipelined #(
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (DEPTH),
        .ADDR_WIDTH   (32),
        .READ_LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_fault   (rsp_fault),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .fault_count (fault_count)
    );

    always #5 clk = ~clk;

    // Expected response for a fetch, straight from the address rules.
    function automatic rsp_t model_rsp(input logic [31:0] a);
        rsp_t r;
        r.fault = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        r.data  = r.fault ? 32'h0 : mem_m[a >> 2];
        return r;
    endfunction

    // One clock: record what the handshakes did this cycle, update the model, return at the next negedge.
    task automatic tick();
        logic        acc, ld, cons;
        logic [31:0] a, la, ldat;
        rsp_t        g;
        #1;
        acc  = req_valid && req_ready;
        ld   = load_en;
        cons = rst_n && rsp_valid && rsp_ready;
        a    = req_addr;
        la   = load_addr;
        ldat = load_data;
        g.data  = rsp_data;
        g.fault = rsp_fault;
        @(posedge clk);
        if (rst_n) begin
            if (ld && la[1:0] == 2'b00 && (la >> 2) < DEPTH) mem_m[la >> 2] = ldat;
            if (acc) exp_q.push_back(model_rsp(a));
            if (cons) begin
                got_q.push_back(g);
                if (g.fault && fc_m != 16'hFFFF) fc_m = fc_m + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(output bit ok);
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!rsp_valid && got_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; load_en = 1'b0;
        req_addr = '0; load_addr = '0; load_data = '0;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault: got %b want 0", rsp_fault); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (fault_count !== 16'h0) begin errors++; $display("FAIL reset_fault_count: got %0d want 0", fault_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        load_en = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_load: got %b want 0", req_ready); end
        load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_fetch();
        bit ok; rsp_t g, e;
        load_en = 1'b1; load_addr = 32'h14; load_data = 32'hDEADBEEF; rsp_ready = 1'b1;
        tick();
        load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h14;
        tick();
        req_valid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lf_early_valid: got %b want 0", rsp_valid); end
        tick(); #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lf_valid_at_2: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lf_data: got %h want deadbeef", rsp_data); end
        checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL lf_fault: got %b want 0", rsp_fault); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lf_drain: got %0d rsps want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL lf_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok; rsp_t g, e;
        logic [31:0] exp_d [3];
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = $urandom;
            exp_d[i] = load_data;
            tick();
        end
        load_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 3); req_addr = 32'(i * 4);
            #1;
            if (i < 3) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
            end
            if (i >= 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d[i-2]) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want v=1 d=%h", i - 2, rsp_valid, rsp_data, exp_d[i-2]);
                end
            end
            tick();
        end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", rsp_valid); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d rsps want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_stall();
        bit ok; rsp_t g, e;
        logic [31:0] v;
        v = $urandom | 32'h1;
        load_en = 1'b1; load_addr = 32'h24; load_data = v; rsp_ready = 1'b0;
        tick();
        load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h24;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== v) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, v);
            end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", k, req_ready); end
            tick();
        end
        rsp_ready = 1'b1; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== v) begin
            errors++; $display("FAIL stall_release: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, v);
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_drain: got %0d rsps want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stall_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_faults();
        bit ok; rsp_t g, e;
        logic [31:0] addrs [3];
        logic [31:0] top_v;
        addrs[0] = 32'hFFC; addrs[1] = 32'h2; addrs[2] = 32'h1000;
        top_v = $urandom | 32'h1;
        load_en = 1'b1; load_addr = 32'hFFC; load_data = top_v; rsp_ready = 1'b1;
        tick();
        load_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = addrs[i];
            tick();
        end
        drain(ok);
        checks++; if (!ok || got_q.size() != 3) begin errors++; $display("FAIL flt_drain: got %0d rsps want 3", got_q.size()); end
        else begin
            checks++; if (got_q[0].fault !== 1'b0 || got_q[0].data !== top_v) begin
                errors++; $display("FAIL flt_last_word: got %h/%b want %h/0", got_q[0].data, got_q[0].fault, top_v);
            end
            checks++; if (got_q[1].fault !== 1'b1 || got_q[1].data !== 32'h0) begin
                errors++; $display("FAIL flt_misaligned: got %h/%b want 0/1", got_q[1].data, got_q[1].fault);
            end
            checks++; if (got_q[2].fault !== 1'b1 || got_q[2].data !== 32'h0) begin
                errors++; $display("FAIL flt_range: got %h/%b want 0/1", got_q[2].data, got_q[2].fault);
            end
        end
        checks++; if (fault_count !== 16'd2) begin errors++; $display("FAIL flt_count: got %0d want 2", fault_count); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL flt_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_load_priority();
        bit ok; rsp_t g, e;
        logic [31:0] v;
        v = $urandom | 32'h1;
        load_en = 1'b1; load_addr = 32'h30; load_data = v;
        req_valid = 1'b1; req_addr = 32'h30; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lp_ready_load: got %b want 0", req_ready); end
        tick();
        load_en = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lp_ready_after: got %b want 1", req_ready); end
        tick();
        drain(ok);
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL lp_drain: got %0d rsps want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0].data !== v || got_q[0].fault !== 1'b0) begin
                errors++; $display("FAIL lp_raw: got %h/%b want %h/0", got_q[0].data, got_q[0].fault, v);
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL lp_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int seen;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h14; tick();
        req_valid = 1'b1; req_addr = 32'h18; tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete(); got_q.delete(); fc_m = 16'h0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", rsp_valid); end
        checks++; if (fault_count !== 16'h0) begin errors++; $display("FAIL rm_count: got %0d want 0", fault_count); end
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rsp_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rm_ghost: got %0d responses want 0", seen); end
        req_valid = 1'b1; req_addr = 32'h14; tick();
        drain(ok);
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL rm_drain: got %0d rsps want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0].data !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_mem_kept: got %h want deadbeef", got_q[0].data); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok; rsp_t g, e;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_fault;
        int          r;
        prev_stall = 1'b0; prev_data = '0; prev_fault = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (prev_stall) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_fault !== prev_fault) begin
                    errors++; $display("FAIL rnd_stall_hold[%0d]: got %b/%h/%b want 1/%h/%b", c, rsp_valid, rsp_data, rsp_fault, prev_data, prev_fault);
                end
            end
            req_valid = ($urandom_range(3) != 0);
            r = $urandom_range(15);
            if (r == 0)      req_addr = ($urandom_range(31) << 2) | 32'($urandom_range(3, 1));
            else if (r == 1) req_addr = 32'h1000 + ($urandom_range(63) << 2);
            else             req_addr = $urandom_range(31) << 2;
            load_en = ($urandom_range(9) == 0);
            r = $urandom_range(7);
            if (r == 5) r = 6;
            load_addr = (r << 2) | ((($urandom_range(7) == 0)) ? 32'h1 : 32'h0);
            load_data = $urandom;
            rsp_ready = ($urandom_range(2) != 0);
            #1;
            checks++; if (req_ready !== (!load_en && !(rsp_valid && !rsp_ready))) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b", c, req_ready);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_fault = rsp_fault;
            tick();
        end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_drain: got %0d rsps want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rnd_sb: got %h/%b want %h/%b", g.data, g.fault, e.data, e.fault); end
        end
        checks++; if (fault_count !== fc_m) begin errors++; $display("FAIL rnd_count: got %0d want %0d", fault_count, fc_m); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        fc_m = 16'h0;
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_stall();
        test_faults();
        test_load_priority();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
